phase_lamp_driver: RTL and testbench

PHASE_LAMP_DRIVER -- requirements
Module: phase_lamp_driver

---
 rtl/phase_lamp_driver_pkg.sv | 55 +++++
 rtl/phase_lamp_driver_if.sv | 20 ++
 rtl/phase_lamp_driver_lamp_blinker.sv | 43 ++++
 rtl/phase_lamp_driver.sv | 130 +++++++++++++
 tb/tb_phase_lamp_driver.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/phase_lamp_driver_pkg.sv
// Shared constants for the phase lamp driver: phase codes, lamp/fault bit
// positions, FSM state encoding and the phase-to-lamp decode.
package phase_lamp_driver_pkg;

    localparam logic [2:0] PH_N_GREEN  = 3'd0;
    localparam logic [2:0] PH_N_YELLOW = 3'd1;
    localparam logic [2:0] PH_RED_1    = 3'd2;
    localparam logic [2:0] PH_E_LEFT   = 3'd3;
    localparam logic [2:0] PH_E_GREEN  = 3'd4;
    localparam logic [2:0] PH_E_YELLOW = 3'd5;
    localparam logic [2:0] PH_RED_2    = 3'd6;
    localparam logic [2:0] PH_N_LEFT   = 3'd7;

    localparam int LAMP_RED_BIT    = 0;
    localparam int LAMP_YELLOW_BIT = 1;
    localparam int LAMP_GREEN_BIT  = 2;
    localparam int LAMP_LEFT_BIT   = 3;

    localparam logic [3:0] L_RED  = 4'(1 << LAMP_RED_BIT);
    localparam logic [3:0] L_YEL  = 4'(1 << LAMP_YELLOW_BIT);
    localparam logic [3:0] L_GRN  = 4'(1 << LAMP_GREEN_BIT);
    localparam logic [3:0] L_LEFT = 4'(1 << LAMP_LEFT_BIT);

    localparam int FC_ILLEGAL_BIT = 0;
    localparam int FC_DWELL_BIT   = 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] n;
        logic [3:0] e;
    } lamp_pair_t;

    // A head that is not being given right of way always shows red.
    function automatic lamp_pair_t decode_phase(input logic [2:0] ph);
        lamp_pair_t lp;
        lp.n = L_RED;
        lp.e = L_RED;
        case (ph)
            PH_N_GREEN:  lp.n = L_GRN;
            PH_N_YELLOW: lp.n = L_YEL;
            PH_E_LEFT:   lp.e = L_LEFT | L_RED;
            PH_E_GREEN:  lp.e = L_GRN;
            PH_E_YELLOW: lp.e = L_YEL;
            PH_N_LEFT:   lp.n = L_LEFT | L_RED;
            default:     lp   = {L_RED, L_RED};
        endcase
        return lp;
    endfunction

endpackage

// File: rtl/phase_lamp_driver_if.sv
// Phase code in, lamp heads and fault status out, between the intersection
// controller (master) and the lamp driver (slave).
interface phase_lamp_driver_if;
    logic [2:0] phase_in;
    logic       clear_fault;
    logic [3:0] n_lamps;
    logic [3:0] e_lamps;
    logic       fault;
    logic [1:0] fault_code;

    modport master (
        output phase_in, clear_fault,
        input  n_lamps, e_lamps, fault, fault_code
    );

    modport slave (
        input  phase_in, clear_fault,
        output n_lamps, e_lamps, fault, fault_code
    );
endinterface

// File: rtl/phase_lamp_driver_lamp_blinker.sv
// Fault blink generator: restart forces the lamp lit, after which it toggles
// every BLINK_DIV cycles.
module lamp_blinker #(
    parameter int BLINK_DIV = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic restart,
    output logic blink
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;

    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (restart) begin
            cnt_d   = '0;
            blink_d = 1'b1;
        end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q   <= '0;
            blink_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q;

endmodule

// File: rtl/phase_lamp_driver.sv
// Lamp driver for a two-head intersection: decodes the controller's phase code,
// polices phase order and dwell, and falls back to blinking red on a fault.
//
// state | meaning
// INIT  | solid all-red for INIT_CYCLES, then adopt current phase unchecked
// RUN   | decode phase each edge, check +1 ordering and minimum dwell
// FAULT | both heads blink red, phase ignored, wait for clear_fault
module phase_lamp_driver
    import phase_lamp_driver_pkg::*;
#(
    parameter int MIN_DWELL   = 4,
    parameter int BLINK_DIV   = 8,
    parameter int INIT_CYCLES = 4
) (
    input logic                clk,
    input logic                resetn,
    phase_lamp_driver_if.slave bus
);

    localparam int DW_W   = $clog2(MIN_DWELL + 1);
    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic [2:0]        phase_q, phase_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    lamp_pair_t        lamps_q, lamps_d;
    logic              fault_q, fault_d;
    logic [1:0]        code_q, code_d;
    logic              blink;
    logic [2:0]        phase_next;
    lamp_pair_t        dec;

    assign phase_next = phase_q + 3'd1;
    assign dec        = decode_phase(bus.phase_in);

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        phase_d    = phase_q;
        dwell_d    = dwell_q;
        lamps_d    = lamps_q;
        fault_d    = fault_q;
        code_d     = code_q;
        case (state_q)
            ST_INIT: begin
                lamps_d = {L_RED, L_RED};
                fault_d = 1'b0;
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                    phase_d    = bus.phase_in;
                    dwell_d    = DW_W'(MIN_DWELL);
                    lamps_d    = dec;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            ST_RUN: begin
                if (bus.phase_in == phase_q) begin
                    lamps_d = dec;
                    if (dwell_q < DW_W'(MIN_DWELL)) begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                end else if (bus.phase_in == phase_next && dwell_q >= DW_W'(MIN_DWELL)) begin
                    phase_d = bus.phase_in;
                    dwell_d = DW_W'(1);
                    lamps_d = dec;
                end else begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    lamps_d = {L_RED, L_RED};
                    if (bus.phase_in == phase_next) begin
                        code_d[FC_DWELL_BIT] = 1'b1;
                    end else begin
                        code_d[FC_ILLEGAL_BIT] = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                if (bus.clear_fault) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                    fault_d    = 1'b0;
                    code_d     = 2'b00;
                    lamps_d    = {L_RED, L_RED};
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            phase_q    <= 3'd0;
            dwell_q    <= '0;
            lamps_q    <= {L_RED, L_RED};
            fault_q    <= 1'b0;
            code_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            phase_q    <= phase_d;
            dwell_q    <= dwell_d;
            lamps_q    <= lamps_d;
            fault_q    <= fault_d;
            code_q     <= code_d;
        end
    end

    // Blinker is held at "lit" outside FAULT so the first half-period starts
    // exactly on the fault-entry edge.
    lamp_blinker #(.BLINK_DIV(BLINK_DIV)) u_blinker (
        .clk     (clk),
        .resetn  (resetn),
        .restart (state_q != ST_FAULT),
        .blink   (blink)
    );

    assign bus.n_lamps    = fault_q ? {3'b000, blink} : lamps_q.n;
    assign bus.e_lamps    = fault_q ? {3'b000, blink} : lamps_q.e;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;

endmodule

// File: tb/tb_phase_lamp_driver.sv
// Bench for phase_lamp_driver: directed vector table, a phase sweep, and
// randomized traffic against a behavioural model of the lamp rules.
module tb_phase_lamp_driver;

    localparam int MIN_DWELL   = 4;
    localparam int BLINK_DIV   = 8;
    localparam int INIT_CYCLES = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    phase_lamp_driver_if bus();

    phase_lamp_driver #(
        .MIN_DWELL   (MIN_DWELL),
        .BLINK_DIV   (BLINK_DIV),
        .INIT_CYCLES (INIT_CYCLES)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = init, 1 = run, 2 = fault
    int         m_mode = 0;
    int         m_age  = 0;
    int         m_phase = 0;
    int         m_held = 0;
    logic [1:0] m_code = 2'b00;
    logic [3:0] m_n = 4'b0001;
    logic [3:0] m_e = 4'b0001;
    logic [3:0] n_tab [8];
    logic [3:0] e_tab [8];

    typedef struct {
        logic       rst;
        logic [2:0] ph;
        logic       clr;
        logic [3:0] n;
        logic [3:0] e;
        logic       f;
        logic [1:0] c;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic rst, input logic [2:0] ph, input logic clr,
                       input logic [3:0] n, input logic [3:0] e,
                       input logic f, input logic [1:0] c);
        vec_t v;
        v.rst = rst; v.ph = ph; v.clr = clr; v.n = n; v.e = e; v.f = f; v.c = c;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input int ph, input logic clr);
        if (!rst) begin
            m_mode = 0; m_age = 0; m_code = 2'b00; m_phase = 0; m_held = 0;
            m_n = 4'b0001; m_e = 4'b0001;
        end else if (m_mode == 0) begin
            if (m_age == INIT_CYCLES - 1) begin
                m_mode = 1; m_phase = ph; m_held = MIN_DWELL;
                m_n = n_tab[ph]; m_e = e_tab[ph];
            end else begin
                m_age++;
            end
        end else if (m_mode == 1) begin
            if (ph == m_phase) begin
                m_held++;
                m_n = n_tab[ph]; m_e = e_tab[ph];
            end else if (ph == (m_phase + 1) % 8) begin
                if (m_held >= MIN_DWELL) begin
                    m_phase = ph; m_held = 1;
                    m_n = n_tab[ph]; m_e = e_tab[ph];
                end else begin
                    m_code[1] = 1'b1; m_mode = 2; m_age = 0;
                end
            end else begin
                m_code[0] = 1'b1; m_mode = 2; m_age = 0;
            end
        end else begin
            if (clr) begin
                m_mode = 0; m_age = 0; m_code = 2'b00;
                m_n = 4'b0001; m_e = 4'b0001;
            end else begin
                m_age++;
            end
        end
    endtask

    // Drive at a falling edge, let the rising edge act, observe at the next fall.
    task automatic apply(input logic rst, input logic [2:0] ph, input logic clr);
        resetn          = rst;
        bus.phase_in    = ph;
        bus.clear_fault = clr;
        @(posedge clk);
        model_edge(rst, int'(ph), clr);
        @(negedge clk);
    endtask

    task automatic cmp_model(input string tag);
        logic [3:0] en, ee;
        logic       lit;
        lit = ((m_age / BLINK_DIV) % 2) == 0;
        en  = (m_mode == 2) ? {3'b000, lit} : m_n;
        ee  = (m_mode == 2) ? {3'b000, lit} : m_e;
        check({tag, " n_lamps"}, bus.n_lamps, en);
        check({tag, " e_lamps"}, bus.e_lamps, ee);
        check({tag, " fault"}, {3'b000, bus.fault}, {3'b000, m_mode == 2});
        check({tag, " fault_code"}, {2'b00, bus.fault_code}, {2'b00, m_code});
    endtask

    initial begin
        logic [2:0] cur;
        int         r;

        n_tab = '{4'b0100, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1001};
        e_tab = '{4'b0001, 4'b0001, 4'b0001, 4'b1001, 4'b0100, 4'b0010, 4'b0001, 4'b0001};

        // reset, INIT, RUN with phase 0
        add(0, 0, 0, 4'b0001, 4'b0001, 0, 2'b00);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 4'b0001, 4'b0001, 0, 2'b00);
        add(1, 0, 0, 4'b0100, 4'b0001, 0, 2'b00);
        // immediate legal +1 (dwell saturated from INIT), hold, step to 2
        add(1, 1, 0, 4'b0010, 4'b0001, 0, 2'b00);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 4'b0010, 4'b0001, 0, 2'b00);
        add(1, 2, 0, 4'b0001, 4'b0001, 0, 2'b00);
        for (int i = 0; i < 3; i++) add(1, 2, 0, 4'b0001, 4'b0001, 0, 2'b00);
        // illegal jump 2 -> 5, blink lit for 8 cycles then dark
        add(1, 5, 0, 4'b0001, 4'b0001, 1, 2'b01);
        for (int i = 0; i < 7; i++) add(1, 5, 0, 4'b0001, 4'b0001, 1, 2'b01);
        add(1, 6, 0, 4'b0000, 4'b0000, 1, 2'b01);
        // clear, INIT 4 cycles, RUN with phase 3
        add(1, 3, 1, 4'b0001, 4'b0001, 0, 2'b00);
        for (int i = 0; i < 3; i++) add(1, 3, 0, 4'b0001, 4'b0001, 0, 2'b00);
        add(1, 3, 0, 4'b0001, 4'b1001, 0, 2'b00);
        // 3 -> 4, clear ignored in RUN, dwell violation 4 -> 5
        add(1, 4, 0, 4'b0001, 4'b0100, 0, 2'b00);
        add(1, 4, 1, 4'b0001, 4'b0100, 0, 2'b00);
        add(1, 5, 0, 4'b0001, 4'b0001, 1, 2'b10);
        add(1, 5, 0, 4'b0001, 4'b0001, 1, 2'b10);
        // reset mid-FAULT, INIT restarts
        add(0, 0, 0, 4'b0001, 4'b0001, 0, 2'b00);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 4'b0001, 4'b0001, 0, 2'b00);
        add(1, 0, 0, 4'b0100, 4'b0001, 0, 2'b00);

        resetn = 1'b0;
        bus.phase_in = 3'd0;
        bus.clear_fault = 1'b0;
        @(negedge clk);

        foreach (vt[k]) begin
            apply(vt[k].rst, vt[k].ph, vt[k].clr);
            check($sformatf("vec%0d n_lamps", k), bus.n_lamps, vt[k].n);
            check($sformatf("vec%0d e_lamps", k), bus.e_lamps, vt[k].e);
            check($sformatf("vec%0d fault", k), {3'b000, bus.fault}, {3'b000, vt[k].f});
            check($sformatf("vec%0d fault_code", k), {2'b00, bus.fault_code}, {2'b00, vt[k].c});
        end

        // sweep 1..7..0..1, each held MIN_DWELL samples, includes 7 -> 0 wrap
        for (int p = 1; p <= 9; p++) begin
            for (int h = 0; h < MIN_DWELL; h++) begin
                apply(1'b1, 3'(p % 8), 1'b0);
                cmp_model($sformatf("sweep p%0d h%0d", p % 8, h));
            end
        end

        // randomized traffic
        cur = 3'(m_phase);
        for (int t = 0; t < 3000; t++) begin
            r = $urandom_range(0, 99);
            if (r >= 70 && r < 92)      cur = cur + 3'd1;
            else if (r >= 92)           cur = 3'($urandom_range(0, 7));
            apply($urandom_range(0, 299) != 0, cur, $urandom_range(0, 11) == 0);
            cmp_model($sformatf("rand t%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
